pc_sequencer: RTL and testbench

Program-counter controller for the single-cycle CPU. It owns the 30-bit word-address PC register and sequences instruction fetch through a req/ack handshake with instruction memory. It selects the next PC from sequential, branch, jump and register-jump sources, and supports halt/resume. It sits between the instruction memory port and the decode/branch logic and replaces the free-running PC register in the fetch path.

---
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter controller for the single-cycle CPU.
// Owns the 30-bit word-address PC and runs instruction fetch through a
// req/ack handshake with instruction memory. The next PC comes from one of
// four sources: sequential, branch, jump or register jump. Halt and resume
// stop and restart fetching.
// Optional feature: define PC_SEQ_TRAP_EN to add the trap input, the epc
// output and the trap vector redirect.
module pc_sequencer #(
    parameter logic [29:0] RESET_PC = 30'h0000000
`ifdef PC_SEQ_TRAP_EN
    ,
    parameter logic [29:0] TRAP_PC  = 30'h0000010
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic [29:0] pc,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        br_taken,
    input  logic [15:0] br_off,
    input  logic        jmp,
    input  logic [25:0] jmp_target,
    input  logic        jr,
    input  logic [29:0] jr_target,
    input  logic        halt,
    input  logic        resume,
    output logic [1:0]  state
`ifdef PC_SEQ_TRAP_EN
    ,
    input  logic        trap,
    output logic [29:0] epc
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FETCH  = 2'b01,
        HALT   = 2'b10,
        UNUSED = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [29:0] r_pc;
    logic [29:0] w_pc_next;
    logic [29:0] w_pc_inc;
    logic [29:0] w_br_sext;
    logic        w_instr_valid;
    logic        w_trap_take;

    // A commit happens only while fetching and memory acknowledges.
    assign w_instr_valid = (r_state == FETCH) && imem_ack;
    assign w_pc_inc      = r_pc + 30'd1;
    assign w_br_sext     = {{14{br_off[15]}}, br_off};

`ifdef PC_SEQ_TRAP_EN
    assign w_trap_take = w_instr_valid && trap;
`else
    assign w_trap_take = 1'b0;
`endif

    // The state register. Reset is asynchronous, so imem_req drops at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A trap keeps fetching even when halt is requested.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = FETCH;
            FETCH:   if (w_instr_valid && halt && !w_trap_take) w_state_next = HALT;
            HALT:    if (resume) w_state_next = FETCH;
            default: w_state_next = IDLE;
        endcase
    end

    // Next-PC selection. Redirect inputs count only on a commit; all adds wrap mod 2^30.
    always_comb begin
        w_pc_next = r_pc;
        if (w_instr_valid) begin
`ifdef PC_SEQ_TRAP_EN
            if (trap)
                w_pc_next = TRAP_PC;
            else
`endif
            if (jr)
                w_pc_next = jr_target;
            else if (jmp)
                w_pc_next = {r_pc[29:26], jmp_target};
            else if (br_taken)
                w_pc_next = w_pc_inc + w_br_sext;
            else
                w_pc_next = w_pc_inc;
        end
    end

    // The PC register. It holds through wait states and HALT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

`ifdef PC_SEQ_TRAP_EN
    logic [29:0] r_epc;

    // Capture the address of the trapping instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_epc <= 30'd0;
        end else if (w_trap_take) begin
            r_epc <= r_pc;
        end
    end

    assign epc = r_epc;
`endif

    assign pc          = r_pc;
    assign imem_req    = (r_state == FETCH);
    assign instr_valid = w_instr_valid;
    assign state       = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer. Stimulus pushes the expected commit PC into a
// scoreboard queue, and a monitor pops and compares it on every instr_valid.
// Define PC_SEQ_TRAP_EN to also exercise the trap path.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [29:0] pc;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic        instr_valid;
    logic        br_taken = 1'b0;
    logic [15:0] br_off = 16'h0;
    logic        jmp = 1'b0;
    logic [25:0] jmp_target = 26'h0;
    logic        jr = 1'b0;
    logic [29:0] jr_target = 30'h0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic [1:0]  state;
`ifdef PC_SEQ_TRAP_EN
    logic        trap = 1'b0;
    logic [29:0] epc;
`endif

    int checks = 0;
    int errors = 0;
    logic [29:0] exp_q[$];

    pc_sequencer dut (
        .clk(clk),
        .rst(rst),
        .pc(pc),
        .imem_req(imem_req),
        .imem_ack(imem_ack),
        .instr_valid(instr_valid),
        .br_taken(br_taken),
        .br_off(br_off),
        .jmp(jmp),
        .jmp_target(jmp_target),
        .jr(jr),
        .jr_target(jr_target),
        .halt(halt),
        .resume(resume),
        .state(state)
`ifdef PC_SEQ_TRAP_EN
        ,
        .trap(trap),
        .epc(epc)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // The monitor compares every commit against the scoreboard.
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit actual=%0h required=none", pc);
            end else begin
                logic [29:0] e;
                e = exp_q.pop_front();
                $display("commit pc=%08h expected=%08h", pc, e);
                check("commit_pc", {2'b0, pc}, {2'b0, e});
            end
        end
    end

    // Runs one committing cycle. It pushes the expected pc and drives the
    // redirect inputs for that cycle.
    task automatic commit(input logic [29:0] exp_pc, input logic b, input logic [15:0] off,
                          input logic j, input logic [25:0] jt, input logic r,
                          input logic [29:0] rt, input logic h);
        exp_q.push_back(exp_pc);
        br_taken = b; br_off = off; jmp = j; jmp_target = jt;
        jr = r; jr_target = rt; halt = h;
        @(posedge clk); #1;
        br_taken = 1'b0; br_off = 16'h0; jmp = 1'b0; jmp_target = 26'h0;
        jr = 1'b0; jr_target = 30'h0; halt = 1'b0;
    endtask

    task automatic seq(input logic [29:0] exp_pc);
        commit(exp_pc, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 30'h0, 1'b0);
    endtask

    task automatic go(input logic [29:0] exp_pc, input logic [29:0] target);
        commit(exp_pc, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, target, 1'b0);
    endtask

    // Time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        #1 rst = 1'b0;
        imem_ack = 1'b1;
        @(posedge clk); #1;
        check("rst_pc", {2'b0, pc}, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_state", {30'b0, state}, 32'h0);
`ifdef PC_SEQ_TRAP_EN
        check("rst_epc", {2'b0, epc}, 32'h0);
`endif
        // Release reset: IDLE for one cycle, then FETCH.
        rst = 1'b1;
        #2 check("idle_req", {31'b0, imem_req}, 32'h0);
        @(posedge clk); #1;
        check("fetch_state", {30'b0, state}, 32'h1);
        check("fetch_req", {31'b0, imem_req}, 32'h1);
        seq(30'h0); seq(30'h1); seq(30'h2);
        go(30'h3, 30'h3FFFFFFF);
        // Sequential wrap at the top of the address space.
        seq(30'h3FFFFFFF);
        go(30'h0, 30'h100);
        // Negative and positive branch offsets.
        commit(30'h100, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 30'h0, 1'b0);
        go(30'h0FF, 30'h100);
        commit(30'h100, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 30'h0, 1'b0);
        // A negative branch from 0 wraps below zero.
        go(30'h105, 30'h0);
        commit(30'h0, 1'b1, 16'hFFF0, 1'b0, 26'h0, 1'b0, 30'h0, 1'b0);
        go(30'h3FFFFFF1, 30'h4000010);
        // Jump beats branch, and jr beats both.
        commit(30'h4000010, 1'b1, 16'h0004, 1'b1, 26'h0000020, 1'b0, 30'h0, 1'b0);
        go(30'h4000020, 30'h4000010);
        commit(30'h4000010, 1'b1, 16'h0004, 1'b1, 26'h0000020, 1'b1, 30'h123, 1'b0);
        go(30'h123, 30'h8);
        // Wait states: pc stays stable with req held high.
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wait_pc", {2'b0, pc}, 32'h8);
            check("wait_req", {31'b0, imem_req}, 32'h1);
            @(posedge clk); #1;
        end
        imem_ack = 1'b1;
        seq(30'h8);
        go(30'h9, 30'h20);
        // Halt: the halting instruction commits and pc advances.
        commit(30'h20, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 30'h0, 1'b1);
        check("halt_state", {30'b0, state}, 32'h2);
        check("halt_req", {31'b0, imem_req}, 32'h0);
        check("halt_pc", {2'b0, pc}, 32'h21);
        // In HALT, ack, halt and jr are ignored.
        halt = 1'b1; jr = 1'b1; jr_target = 30'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        halt = 1'b0; jr = 1'b0; jr_target = 30'h0;
        check("halt_hold_pc", {2'b0, pc}, 32'h21);
        check("halt_hold_state", {30'b0, state}, 32'h2);
        resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        check("resume_state", {30'b0, state}, 32'h1);
        check("resume_pc", {2'b0, pc}, 32'h21);
        seq(30'h21);
        go(30'h22, 30'h8);
        // Reset asserted during a wait state.
        imem_ack = 1'b0;
        check("abort_wait_pc", {2'b0, pc}, 32'h8);
        #2 rst = 1'b0;
        #1;
        check("abort_pc", {2'b0, pc}, 32'h0);
        check("abort_req", {31'b0, imem_req}, 32'h0);
        imem_ack = 1'b1;
        #1 check("abort_valid", {31'b0, instr_valid}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        seq(30'h0);
`ifdef PC_SEQ_TRAP_EN
        go(30'h1, 30'h55);
        // A trap beats jr and halt.
        trap = 1'b1;
        commit(30'h55, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 30'h77, 1'b1);
        trap = 1'b0;
        check("trap_epc", {2'b0, epc}, 32'h55);
        check("trap_state", {30'b0, state}, 32'h1);
        seq(30'h10);
`else
        seq(30'h1);
`endif
        imem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("queue_empty", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
